// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

  // Out-of-range fetches and explicit halt instructions both read as HALT_WORD.
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/instruction_memory.sv
// Instruction storage: one synchronous write port, one asynchronous read port, no reset.
//   clock  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data (combinational)
module instruction_memory #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : instruction_memory

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: loads instruction memory over a valid/ready stream, then fetches
// the word at pc_address into the IF/ID register, handling stall/flush/halt.
//   clock, reset_n     : clock, async active-low reset
//   load_*             : program loader stream (accepted only in LOAD)
//   pc_address         : current PC
//   write_pc           : PC update enable (combinational)
//   stall, flush       : hazard hold / branch squash
//   if_id_*            : registered IF/ID payload
//   halted             : stage is in HALT (combinational)
module instruction_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic [ADDR_WIDTH-1:0] pc_address,
  output logic                  write_pc,
  input  logic                  stall,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] if_id_instruction,
  output logic [ADDR_WIDTH-1:0] if_id_pc_next,
  output logic                  if_id_valid,
  output logic                  halted
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [DATA_WIDTH-1:0] HALT_W   = DATA_WIDTH'(HALT_WORD);
  localparam logic [DATA_WIDTH-1:0] NOP_W    = DATA_WIDTH'(NOP_WORD);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] load_ptr_q, load_ptr_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] pc_next_q, pc_next_d;
  logic                  valid_q, valid_d;

  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] fetch_word;
  logic                  halt_detect;

  assign mem_we = (state_q == ST_LOAD) && load_valid;

  instruction_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_imem (
    .clock (clock),
    .we    (mem_we),
    .waddr (load_ptr_q),
    .wdata (load_data),
    .raddr (pc_address),
    .rdata (mem_rdata)
  );

  // Words past the loaded program (including stale contents) read as halt.
  assign fetch_word  = ({1'b0, pc_address} < word_count_q) ? mem_rdata : HALT_W;
  assign halt_detect = (fetch_word == HALT_W);

  // Next-state, IF/ID update and combinational handshake outputs.
  always_comb begin
    state_d      = state_q;
    load_ptr_d   = load_ptr_q;
    word_count_d = word_count_q;
    instr_d      = instr_q;
    pc_next_d    = pc_next_q;
    valid_d      = valid_q;
    load_ready   = 1'b0;
    write_pc     = 1'b0;
    halted       = 1'b0;

    case (state_q)
      ST_LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          word_count_d = word_count_q + CNT_WIDTH'(1);
          // Pointer saturates at the last slot; the 32nd word ends the load.
          if (load_ptr_q != ADDR_MAX) begin
            load_ptr_d = load_ptr_q + ADDR_WIDTH'(1);
          end
          if (load_last || (load_ptr_q == ADDR_MAX)) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        write_pc = !stall && !halt_detect && !flush;
        // Flush beats halt: a halt word on a squashed path must not stop the core.
        if (flush) begin
          valid_d = 1'b0;
          instr_d = NOP_W;
        end else if (stall) begin
          valid_d = valid_q;
        end else if (halt_detect) begin
          valid_d = 1'b0;
          instr_d = NOP_W;
          state_d = ST_HALT;
        end else begin
          instr_d   = fetch_word;
          pc_next_d = pc_address + ADDR_WIDTH'(1);
          valid_d   = 1'b1;
        end
      end

      ST_HALT: begin
        halted = 1'b1;
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, counters and IF/ID register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_LOAD;
      load_ptr_q   <= '0;
      word_count_q <= '0;
      instr_q      <= NOP_W;
      pc_next_q    <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ptr_q   <= load_ptr_d;
      word_count_q <= word_count_d;
      instr_q      <= instr_d;
      pc_next_q    <= pc_next_d;
      valid_q      <= valid_d;
    end
  end

  assign if_id_instruction = instr_q;
  assign if_id_pc_next     = pc_next_q;
  assign if_id_valid       = valid_q;

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed stimulus pushes the
// expected IF/ID payload for every cycle a valid instruction should appear;
// a monitor pops and compares whenever if_id_valid is high.
module tb_instruction_fetch_stage;

  logic        clock;
  logic        reset_n;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_data;
  logic        load_last;
  logic [4:0]  pc_address;
  logic        write_pc;
  logic        stall;
  logic        flush;
  logic [31:0] if_id_instruction;
  logic [4:0]  if_id_pc_next;
  logic        if_id_valid;
  logic        halted;

  typedef struct packed {
    logic [31:0] instr;
    logic [4:0]  pcn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_stage dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_data         (load_data),
    .load_last         (load_last),
    .pc_address        (pc_address),
    .write_pc          (write_pc),
    .stall             (stall),
    .flush             (flush),
    .if_id_instruction (if_id_instruction),
    .if_id_pc_next     (if_id_pc_next),
    .if_id_valid       (if_id_valid),
    .halted            (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [4:0] pcn);
    exp_t e;
    e.instr = instr;
    e.pcn   = pcn;
    exp_q.push_back(e);
  endtask

  // Inputs change on the falling edge; combinational outputs are settled at +1.
  task automatic drive(input logic lv, input logic [31:0] ld, input logic ll,
                       input logic [4:0] pc, input logic st, input logic fl);
    @(negedge clock);
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    pc_address = pc;
    stall      = st;
    flush      = fl;
    #1;
  endtask

  task automatic idle(input logic [4:0] pc);
    drive(1'b0, 32'h0, 1'b0, pc, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clock);
    #2;
    load_valid = 1'b0;
    load_last  = 1'b0;
    stall      = 1'b0;
    flush      = 1'b0;
    reset_n    = 1'b0;
    #1;
    chk({tag, "_rst_load_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_rst_write_pc"}, 32'(write_pc), 32'd0);
    chk({tag, "_rst_halted"}, 32'(halted), 32'd0);
    chk({tag, "_rst_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_rst_instr"}, if_id_instruction, 32'd0);
    chk({tag, "_rst_pcn"}, 32'(if_id_pc_next), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: every valid IF/ID presentation must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n && if_id_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got instr %h pcn %0d expected no valid (t=%0t)",
                   if_id_instruction, if_id_pc_next, $time);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", if_id_instruction, e.instr);
          chk("sb_pc_next", 32'(if_id_pc_next), 32'(e.pcn));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    load_valid = 1'b0;
    load_data  = 32'h0;
    load_last  = 1'b0;
    pc_address = 5'd0;
    stall      = 1'b0;
    flush      = 1'b0;
    #1;
    chk("init_load_ready", 32'(load_ready), 32'd1);
    chk("init_write_pc", 32'(write_pc), 32'd0);
    chk("init_halted", 32'(halted), 32'd0);
    chk("init_valid", 32'(if_id_valid), 32'd0);
    chk("init_instr", if_id_instruction, 32'd0);
    chk("init_pcn", 32'(if_id_pc_next), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;

    // Load A,B,C with last on C, then fetch 0..2.
    drive(1'b1, 32'hAAAA_0001, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("t1_load_ready_a", 32'(load_ready), 32'd1);
    chk("t1_write_pc_load", 32'(write_pc), 32'd0);
    drive(1'b1, 32'hBBBB_0002, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 32'hCCCC_0003, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("t1_load_ready_c", 32'(load_ready), 32'd1);
    idle(5'd0);
    chk("t1_load_ready_run", 32'(load_ready), 32'd0);
    chk("t1_write_pc_run", 32'(write_pc), 32'd1);
    push(32'hAAAA_0001, 5'd1);
    idle(5'd1);
    push(32'hBBBB_0002, 5'd2);
    idle(5'd2);
    push(32'hCCCC_0003, 5'd3);

    // Load 2 words; pc=2 is past the program (stale C there) and halts.
    do_reset("t3");
    drive(1'b1, 32'hD0D0_0000, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b1, 32'hD1D1_0001, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(5'd0);
    push(32'hD0D0_0000, 5'd1);
    idle(5'd2);
    chk("t3_write_pc_halt", 32'(write_pc), 32'd0);
    drive(1'b0, 32'h0, 1'b0, 5'd2, 1'b1, 1'b1);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_valid_bubble", 32'(if_id_valid), 32'd0);
    chk("t3_write_pc_halted", 32'(write_pc), 32'd0);
    idle(5'd0);
    chk("t3_halted_after_sf", 32'(halted), 32'd1);
    chk("t3_valid_after_sf", 32'(if_id_valid), 32'd0);
    chk("t3_write_pc_after_sf", 32'(write_pc), 32'd0);

    // Load 32 words without last; wrap of pc_next at 31; stall then stall+flush.
    do_reset("t2");
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 1'b0);
      if (i == 31) chk("t2_load_ready_w31", 32'(load_ready), 32'd1);
    end
    idle(5'd31);
    chk("t2_load_ready_run", 32'(load_ready), 32'd0);
    chk("t2_write_pc_31", 32'(write_pc), 32'd1);
    push(32'h1000_001F, 5'd0);
    idle(5'd0);
    push(32'h1000_0000, 5'd1);
    idle(5'd5);
    push(32'h1000_0005, 5'd6);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b0);
      chk("t4_write_pc_stall", 32'(write_pc), 32'd0);
      push(32'h1000_0005, 5'd6);
    end
    drive(1'b0, 32'h0, 1'b0, 5'd6, 1'b1, 1'b1);
    chk("t4_write_pc_sf", 32'(write_pc), 32'd0);
    idle(5'd7);
    chk("t4_valid_flushed", 32'(if_id_valid), 32'd0);
    chk("t4_instr_flushed", if_id_instruction, 32'd0);
    chk("t4_write_pc_resume", 32'(write_pc), 32'd1);
    push(32'h1000_0007, 5'd8);

    // Halt word at pc=1 coincident with flush: stays RUN.
    do_reset("t5");
    for (int i = 0; i < 6; i++) begin
      logic [31:0] w;
      w = (i == 1) ? 32'hFFFF_FFFF : (32'hA5A5_0000 + 32'(i));
      drive(1'b1, w, (i == 5), 5'd0, 1'b0, 1'b0);
    end
    idle(5'd0);
    push(32'hA5A5_0000, 5'd1);
    drive(1'b0, 32'h0, 1'b0, 5'd1, 1'b0, 1'b1);
    chk("t5_write_pc_flush_halt", 32'(write_pc), 32'd0);
    idle(5'd5);
    chk("t5_valid_bubble", 32'(if_id_valid), 32'd0);
    chk("t5_instr_bubble", if_id_instruction, 32'd0);
    chk("t5_not_halted", 32'(halted), 32'd0);
    chk("t5_write_pc_pc5", 32'(write_pc), 32'd1);
    push(32'hA5A5_0005, 5'd6);

    // Reset mid-RUN, reload one word, pc=1 halts.
    do_reset("t6");
    drive(1'b1, 32'h7777_0000, 1'b1, 5'd0, 1'b0, 1'b0);
    idle(5'd1);
    chk("t6_write_pc_halt", 32'(write_pc), 32'd0);
    idle(5'd1);
    chk("t6_halted", 32'(halted), 32'd1);
    chk("t6_valid", 32'(if_id_valid), 32'd0);

    idle(5'd0);
    idle(5'd0);
    chk("sb_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_instruction_fetch_stage
